// File: rtl/lsu_align_if.sv
`default_nettype none
// ------------------------------------------------------------------
// lsu_align_if: CPU request bus and dmem port bundle for lsu_align
// Rev 1.0
// ------------------------------------------------------------------
interface lsu_align_if #(
  parameter int AW = 32
) ();
  logic          req;
  logic          memwrite;
  logic [1:0]    size;
  logic          uns;
  logic [AW-1:0] addr;
  logic [31:0]   wdata;
  logic [31:0]   rdata;
  logic          stall;
  logic          misalign;
  logic          dmem_we;
  logic [AW-1:0] dmem_a;
  logic [31:0]   dmem_wd;
  logic [31:0]   dmem_rd;

  // Environment side: the CPU datapath together with the word memory.
  modport master (
    output req, memwrite, size, uns, addr, wdata, dmem_rd,
    input  rdata, stall, misalign, dmem_we, dmem_a, dmem_wd
  );

  modport slave (
    input  req, memwrite, size, uns, addr, wdata, dmem_rd,
    output rdata, stall, misalign, dmem_we, dmem_a, dmem_wd
  );
endinterface
`default_nettype wire

// File: rtl/lsu_align.sv
`default_nettype none
// ------------------------------------------------------------------
// lsu_align: big-endian byte/halfword load-store alignment over word dmem
// Rev 1.0
// ------------------------------------------------------------------
module lsu_align #(
  parameter int AW = 32
) (
  input  logic       clk,
  input  logic       resetn,
  lsu_align_if.slave bus
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] sv_addr_q, sv_addr_d;
  logic [31:0]   sv_word_q, sv_word_d;

  logic [AW-1:0] word_addr;
  logic [1:0]    off;
  logic          mis;
  logic [7:0]    byte_lane;
  logic [15:0]   half_lane;
  logic [31:0]   lane_ext;
  logic [31:0]   merged;

  logic [31:0]   rdata_w;
  logic          stall_w;
  logic          mis_w;
  logic          we_w;
  logic [AW-1:0] a_w;
  logic [31:0]   wd_w;

  assign word_addr = {bus.addr[AW-1:2], 2'b00};
  assign off       = bus.addr[1:0];

  assign mis = bus.req &&
               ((bus.size == 2'b11) ||
                (bus.size == 2'b01 && bus.addr[0]) ||
                (bus.size == 2'b10 && bus.addr[1:0] != 2'b00));

  // Big-endian lanes: offset 0 is the most significant byte.
  always_comb begin
    byte_lane = 8'h00;
    case (off)
      2'b00:   byte_lane = bus.dmem_rd[31:24];
      2'b01:   byte_lane = bus.dmem_rd[23:16];
      2'b10:   byte_lane = bus.dmem_rd[15:8];
      default: byte_lane = bus.dmem_rd[7:0];
    endcase
    half_lane = off[1] ? bus.dmem_rd[15:0] : bus.dmem_rd[31:16];
  end

  always_comb begin
    lane_ext = bus.dmem_rd;
    case (bus.size)
      2'b00:   lane_ext = bus.uns ? {24'h000000, byte_lane}
                                  : {{24{byte_lane[7]}}, byte_lane};
      2'b01:   lane_ext = bus.uns ? {16'h0000, half_lane}
                                  : {{16{half_lane[15]}}, half_lane};
      default: lane_ext = bus.dmem_rd;
    endcase
  end

  // Word to be written back by a sub-word store: old word with one lane replaced.
  always_comb begin
    merged = bus.dmem_rd;
    if (bus.size == 2'b00) begin
      case (off)
        2'b00:   merged[31:24] = bus.wdata[7:0];
        2'b01:   merged[23:16] = bus.wdata[7:0];
        2'b10:   merged[15:8]  = bus.wdata[7:0];
        default: merged[7:0]   = bus.wdata[7:0];
      endcase
    end else if (off[1]) begin
      merged[15:0] = bus.wdata[15:0];
    end else begin
      merged[31:16] = bus.wdata[15:0];
    end
  end

  always_comb begin
    state_d   = state_q;
    sv_addr_d = sv_addr_q;
    sv_word_d = sv_word_q;
    rdata_w   = 32'h0000_0000;
    stall_w   = 1'b0;
    mis_w     = 1'b0;
    we_w      = 1'b0;
    a_w       = word_addr;
    wd_w      = 32'h0000_0000;

    case (state_q)
      IDLE: begin
        if (mis) begin
          mis_w = 1'b1;
        end else if (bus.req) begin
          if (!bus.memwrite) begin
            rdata_w = lane_ext;
          end else if (bus.size == 2'b10) begin
            we_w = 1'b1;
            wd_w = bus.wdata;
          end else begin
            stall_w   = 1'b1;
            sv_word_d = merged;
            sv_addr_d = word_addr;
            state_d   = WRITE;
          end
        end
      end
      WRITE: begin
        // CPU inputs are deliberately ignored; the captured word always commits.
        we_w    = 1'b1;
        a_w     = sv_addr_q;
        wd_w    = sv_word_q;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= IDLE;
      sv_addr_q <= '0;
      sv_word_q <= 32'h0000_0000;
    end else begin
      state_q   <= state_d;
      sv_addr_q <= sv_addr_d;
      sv_word_q <= sv_word_d;
    end
  end

  assign bus.rdata    = rdata_w;
  assign bus.stall    = stall_w;
  assign bus.misalign = mis_w;
  assign bus.dmem_we  = we_w & resetn;
  assign bus.dmem_a   = a_w;
  assign bus.dmem_wd  = wd_w;

endmodule
`default_nettype wire

// File: tb/tb_lsu_align.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_lsu_align: vector-table and scoreboard bench for lsu_align
// Rev 1.0
// ------------------------------------------------------------------
module tb_lsu_align;

  typedef struct {
    logic        rn;
    logic        req;
    logic        mw;
    logic [1:0]  sz;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        stall;
    logic        mis;
    logic        we;
    logic [31:0] a;
    logic [31:0] wd;
  } vec_t;

  logic        clk;
  logic        resetn;
  logic [31:0] ram [0:15];
  int          n_cmp;
  int          n_fail;
  int          n_wr;
  vec_t        sb_q [$];
  string       tag_q [$];
  vec_t        tbl [$];

  lsu_align_if #(.AW(32)) bus ();

  lsu_align #(.AW(32)) u_dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign bus.dmem_rd = ram[bus.dmem_a[5:2]];

  always @(posedge clk) begin
    if (bus.dmem_we === 1'b1) begin
      ram[bus.dmem_a[5:2]] <= bus.dmem_wd;
      n_wr = n_wr + 1;
    end
  end

  function automatic vec_t mk(logic rn, logic req, logic mw, logic [1:0] sz, logic uns,
                              logic [31:0] addr, logic [31:0] wdata, logic [31:0] rdata,
                              logic stall, logic mis, logic we, logic [31:0] a, logic [31:0] wd);
    vec_t v;
    v.rn = rn; v.req = req; v.mw = mw; v.sz = sz; v.uns = uns; v.addr = addr; v.wdata = wdata;
    v.rdata = rdata; v.stall = stall; v.mis = mis; v.we = we; v.a = a; v.wd = wd;
    return v;
  endfunction

  function automatic vec_t ld(logic [1:0] sz, logic uns, logic [31:0] addr, logic [31:0] rdata);
    return mk(1'b1, 1'b1, 1'b0, sz, uns, addr, 32'h0, rdata, 1'b0, 1'b0, 1'b0,
              addr & 32'hFFFF_FFFC, 32'h0);
  endfunction

  function automatic logic [31:0] ld_model(logic [31:0] w, logic [1:0] sz, logic u, logic [1:0] off);
    logic [31:0] t;
    case (sz)
      2'd0: begin
        t = w << (8 * off);
        t = u ? (t >> 24) : $unsigned($signed(t) >>> 24);
      end
      2'd1: begin
        t = w << (16 * off[1]);
        t = u ? (t >> 16) : $unsigned($signed(t) >>> 16);
      end
      default: t = w;
    endcase
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (act !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check_out();
    vec_t  e;
    string t;
    e = sb_q.pop_front();
    t = tag_q.pop_front();
    chk({t, " rdata"},    bus.rdata, e.rdata);
    chk({t, " stall"},    {31'b0, bus.stall}, {31'b0, e.stall});
    chk({t, " misalign"}, {31'b0, bus.misalign}, {31'b0, e.mis});
    chk({t, " dmem_we"},  {31'b0, bus.dmem_we}, {31'b0, e.we});
    chk({t, " dmem_a"},   bus.dmem_a, e.a);
    if (e.we) chk({t, " dmem_wd"}, bus.dmem_wd, e.wd);
  endtask

  task automatic step(input vec_t v, input string tag);
    @(posedge clk);
    #1;
    resetn       = v.rn;
    bus.req      = v.req;
    bus.memwrite = v.mw;
    bus.size     = v.sz;
    bus.uns      = v.uns;
    bus.addr     = v.addr;
    bus.wdata    = v.wdata;
    sb_q.push_back(v);
    tag_q.push_back(tag);
    @(negedge clk);
    check_out();
  endtask

  initial begin
    n_cmp = 0; n_fail = 0; n_wr = 0;
    resetn = 1'b0;
    bus.req = 1'b0; bus.memwrite = 1'b0; bus.size = 2'b00; bus.uns = 1'b0;
    bus.addr = 32'h0; bus.wdata = 32'h0;
    for (int i = 0; i < 16; i++) ram[i] = 32'h0;
    ram[0] = 32'h5566_7788;
    ram[1] = 32'h80FF_7F01;
    ram[2] = 32'h1122_3344;
    ram[3] = 32'h1122_3344;

    // rn req mw sz uns addr wdata | rdata stall mis we a wd
    tbl.push_back(mk(0, 0, 0, 2'd0, 0, 32'h0,  32'h0, 32'h0, 0, 0, 0, 32'h0, 32'h0));
    tbl.push_back(mk(1, 0, 0, 2'd0, 0, 32'h12, 32'h0, 32'h0, 0, 0, 0, 32'h10, 32'h0));
    tbl.push_back(ld(2'd0, 0, 32'h4, 32'hFFFF_FF80));
    tbl.push_back(ld(2'd0, 1, 32'h4, 32'h0000_0080));
    tbl.push_back(ld(2'd1, 0, 32'h6, 32'h0000_7F01));
    tbl.push_back(ld(2'd1, 1, 32'h4, 32'h0000_80FF));
    tbl.push_back(ld(2'd1, 0, 32'h4, 32'hFFFF_80FF));
    tbl.push_back(ld(2'd0, 0, 32'h5, 32'hFFFF_FFFF));
    tbl.push_back(ld(2'd0, 0, 32'h7, 32'h0000_0001));
    tbl.push_back(ld(2'd2, 0, 32'h4, 32'h80FF_7F01));
    tbl.push_back(mk(1, 1, 1, 2'd0, 0, 32'h9, 32'hAB, 32'h0, 1, 0, 0, 32'h8, 32'h0));
    tbl.push_back(mk(1, 0, 0, 2'd0, 0, 32'h0, 32'h0,  32'h0, 0, 0, 1, 32'h8, 32'h11AB_3344));
    tbl.push_back(ld(2'd2, 0, 32'h8, 32'h11AB_3344));
    tbl.push_back(mk(1, 1, 1, 2'd1, 0, 32'hE, 32'hDEAD_BEEF, 32'h0, 1, 0, 0, 32'hC, 32'h0));
    tbl.push_back(mk(1, 1, 1, 2'd1, 0, 32'hE, 32'hDEAD_BEEF, 32'h0, 0, 0, 1, 32'hC, 32'h1122_BEEF));
    tbl.push_back(ld(2'd2, 0, 32'hC, 32'h1122_BEEF));
    tbl.push_back(mk(1, 1, 1, 2'd2, 0, 32'hC, 32'hCAFE_F00D, 32'h0, 0, 0, 1, 32'hC, 32'hCAFE_F00D));
    tbl.push_back(ld(2'd2, 0, 32'hC, 32'hCAFE_F00D));
    tbl.push_back(mk(1, 1, 0, 2'd2, 0, 32'h5, 32'h0, 32'h0, 0, 1, 0, 32'h4, 32'h0));
    tbl.push_back(mk(1, 1, 1, 2'd1, 0, 32'h3, 32'hFFFF, 32'h0, 0, 1, 0, 32'h0, 32'h0));
    tbl.push_back(mk(1, 1, 0, 2'd3, 0, 32'h8, 32'h0, 32'h0, 0, 1, 0, 32'h8, 32'h0));
    tbl.push_back(mk(1, 1, 1, 2'd2, 0, 32'h2, 32'h1234, 32'h0, 0, 1, 0, 32'h0, 32'h0));
    tbl.push_back(mk(1, 0, 0, 2'd0, 0, 32'h0, 32'h0, 32'h0, 0, 0, 0, 32'h0, 32'h0));

    for (int i = 0; i < tbl.size(); i++) step(tbl[i], $sformatf("vec%0d", i));

    chk("ram0 after table", ram[0], 32'h5566_7788);
    chk("ram2 after sb",    ram[2], 32'h11AB_3344);
    chk("ram3 after sh/sw", ram[3], 32'hCAFE_F00D);

    // Reset lands on the write-back cycle of a byte store.
    step(mk(1, 1, 1, 2'd0, 0, 32'h0, 32'h99, 32'h0, 1, 0, 0, 32'h0, 32'h0), "rst_sb");
    step(mk(0, 0, 0, 2'd0, 0, 32'h0, 32'h0,  32'h0, 0, 0, 0, 32'h0, 32'h0), "rst_write");
    step(mk(1, 0, 0, 2'd0, 0, 32'h0, 32'h0,  32'h0, 0, 0, 0, 32'h0, 32'h0), "rst_after");
    step(ld(2'd2, 0, 32'h0, 32'h5566_7788), "rst_lw");
    chk("ram0 after reset", ram[0], 32'h5566_7788);

    // Back-to-back sb, lbu of the stored byte, sw.
    step(mk(1, 1, 1, 2'd0, 0, 32'h1, 32'h5A, 32'h0, 1, 0, 0, 32'h0, 32'h0), "b2b_sb");
    step(mk(1, 1, 1, 2'd0, 0, 32'h1, 32'h5A, 32'h0, 0, 0, 1, 32'h0, 32'h555A_7788), "b2b_write");
    step(ld(2'd0, 1, 32'h1, 32'h0000_005A), "b2b_lbu");
    step(mk(1, 1, 1, 2'd2, 0, 32'h0, 32'h0102_0304, 32'h0, 0, 0, 1, 32'h0, 32'h0102_0304), "b2b_sw");
    step(mk(1, 0, 0, 2'd0, 0, 32'h0, 32'h0, 32'h0, 0, 0, 0, 32'h0, 32'h0), "b2b_idle");
    chk("ram0 after b2b", ram[0], 32'h0102_0304);

    for (int i = 0; i < 24; i++) begin
      logic [31:0] a;
      logic [1:0]  sz;
      logic        u;
      logic        m;
      a  = 32'($urandom_range(0, 15));
      sz = 2'($urandom_range(0, 3));
      u  = 1'($urandom_range(0, 1));
      m  = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'b00);
      step(mk(1, 1, 0, sz, u, a, 32'h0,
              m ? 32'h0 : ld_model(ram[a[3:2]], sz, u, a[1:0]),
              0, m, 0, a & 32'hFFFF_FFFC, 32'h0), $sformatf("rnd%0d", i));
    end

    chk("total writes", 32'(n_wr), 32'd5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
